// File: rtl/mips_alu_reg.sv
// 32-bit MIPS execute-stage ALU: add/sub, logic, shift and compare units
// feeding a single output register for the result and status flags.
module mips_alu_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sign,
  input  logic [5:0]       ALUFun,
  output logic [WIDTH-1:0] Z,
  output logic             Zero,
  output logic             Overflow,
  output logic             Negative
);

  typedef enum logic [1:0] {
    U_ARITH = 2'b00,
    U_LOGIC = 2'b01,
    U_SHIFT = 2'b10,
    U_CMP   = 2'b11
  } unit_e;

  unit_e            unit;
  logic             sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s;
  logic             carry;
  logic             ov_s;
  logic             as_ov;
  logic             as_neg;
  logic [4:0]       shamt;
  logic             cond;

  logic [WIDTH-1:0] z_d, z_q;
  logic             zero_d, zero_q;
  logic             overflow_d, overflow_q;
  logic             negative_d, negative_q;

  // Shared adder: compare ops always run it as A - B.
  always_comb begin
    unit  = unit_e'(ALUFun[5:4]);
    sub   = (unit == U_CMP) | ALUFun[0];
    b_op  = sub ? ~B : B;
    sum   = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
    s     = sum[WIDTH-1:0];
    carry = sum[WIDTH];
    if (sub) ov_s = (A[WIDTH-1] != B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]);
    else     ov_s = (A[WIDTH-1] == B[WIDTH-1]) && (s[WIDTH-1] != A[WIDTH-1]);
    // Unsigned: carry for add, borrow (no carry out) for sub.
    as_ov  = Sign ? ov_s : (sub ? ~carry : carry);
    as_neg = Sign ? (s[WIDTH-1] ^ ov_s) : (sub ? ~carry : 1'b0);
  end

  always_comb begin
    shamt      = A[4:0];
    cond       = 1'b0;
    z_d        = '0;
    overflow_d = 1'b0;
    negative_d = 1'b0;
    case (unit)
      U_ARITH: begin
        z_d        = s;
        overflow_d = as_ov;
        negative_d = as_neg;
      end
      U_LOGIC: begin
        case (ALUFun)
          6'b011000: z_d = A & B;
          6'b011110: z_d = A | B;
          6'b010110: z_d = A ^ B;
          6'b010001: z_d = ~(A | B);
          6'b011010: z_d = A;
          default:   z_d = '0;
        endcase
      end
      U_SHIFT: begin
        case (ALUFun)
          6'b100000: z_d = B << shamt;
          6'b100001: z_d = B >> shamt;
          6'b100011: z_d = $unsigned($signed(B) >>> shamt);
          default:   z_d = '0;
        endcase
      end
      U_CMP: begin
        case (ALUFun)
          6'b110011, 6'b110001, 6'b110101,
          6'b111101, 6'b111011, 6'b111111: begin
            case (ALUFun)
              6'b110011: cond = (s == '0);
              6'b110001: cond = (s != '0);
              6'b110101: cond = as_neg;
              6'b111101: cond = A[WIDTH-1] | (A == '0);
              6'b111011: cond = A[WIDTH-1];
              default:   cond = ~A[WIDTH-1] & (A != '0);
            endcase
            z_d        = {{(WIDTH-1){1'b0}}, cond};
            overflow_d = as_ov;
            negative_d = as_neg;
          end
          default: z_d = '0;
        endcase
      end
      default: z_d = '0;
    endcase
    zero_d = (z_d == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q        <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      z_q        <= z_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end

  assign Z        = z_q;
  assign Zero     = zero_q;
  assign Overflow = overflow_q;
  assign Negative = negative_q;

endmodule

// File: tb/tb_mips_alu_reg.sv
// Scoreboard bench for mips_alu_reg: directed and random ops, expected
// results from an arithmetic reference model, checked one cycle later.
module tb_mips_alu_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic        Sign;
  logic [5:0]  ALUFun;
  logic [31:0] Z;
  logic        Zero, Overflow, Negative;

  always #5 clk = ~clk;

  mips_alu_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Sign(Sign), .ALUFun(ALUFun),
    .Z(Z), .Zero(Zero), .Overflow(Overflow), .Negative(Negative)
  );

  typedef struct packed {
    logic [31:0] z;
    logic        zero;
    logic        ov;
    logic        neg;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMAX = 64'sd4294967295;

  logic [5:0] codes [0:15] = '{6'b000000, 6'b000001, 6'b001110, 6'b001011,
                               6'b011000, 6'b011110, 6'b010110, 6'b010001,
                               6'b011010, 6'b100000, 6'b100001, 6'b100011,
                               6'b110011, 6'b110001, 6'b110101, 6'b111101};
  logic [31:0] specials [0:7] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'h80000001, 32'h2, 32'h4};

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sg, input logic [5:0] f);
    exp_t   e;
    longint sa, sb, ua, ub, r;
    logic   sov, sneg, c;
    e  = '0;
    c  = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = sa - sb;
    if (sg) begin
      sov  = (r > SMAX) || (r < SMIN);
      sneg = (r < 0);
    end else begin
      sov  = (ua < ub);
      sneg = (ua < ub);
    end
    if (f[5:4] == 2'b00) begin
      if (f[0]) begin
        e.z = a - b; e.ov = sov; e.neg = sneg;
      end else begin
        e.z = a + b;
        if (sg) begin
          r = sa + sb; e.ov = (r > SMAX) || (r < SMIN); e.neg = (r < 0);
        end else begin
          r = ua + ub; e.ov = (r > UMAX); e.neg = 1'b0;
        end
      end
    end else begin
      case (f)
        6'b011000: e.z = a & b;
        6'b011110: e.z = a | b;
        6'b010110: e.z = a ^ b;
        6'b010001: e.z = ~(a | b);
        6'b011010: e.z = a;
        6'b100000: e.z = b << a[4:0];
        6'b100001: e.z = b >> a[4:0];
        6'b100011: e.z = $unsigned($signed(b) >>> a[4:0]);
        6'b110011, 6'b110001, 6'b110101, 6'b111101, 6'b111011, 6'b111111: begin
          case (f)
            6'b110011: c = (a == b);
            6'b110001: c = (a != b);
            6'b110101: c = sneg;
            6'b111101: c = (sa <= 0);
            6'b111011: c = (sa < 0);
            default:   c = (sa > 0);
          endcase
          e.z = {31'b0, c}; e.ov = sov; e.neg = sneg;
        end
        default: e.z = '0;
      endcase
    end
    e.zero = (e.z == 32'h0);
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [5:0] f, input exp_t e, input string nm);
    A = a; B = b; Sign = sg; ALUFun = f;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic issue_exp(input logic [31:0] a, input logic [31:0] b, input logic sg,
                           input logic [5:0] f, input exp_t e, input string nm);
    @(negedge clk);
    drive(a, b, sg, f, e, nm);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                       input logic [5:0] f, input string nm);
    @(negedge clk);
    drive(a, b, sg, f, model(a, b, sg, f), nm);
  endtask

  task automatic check_now(input string nm, input exp_t e);
    n_checks++;
    if ({Z, Zero, Overflow, Negative} === e) n_pass++;
    else $display("FAIL %s: got Z=%h Zero=%b Ov=%b Neg=%b, expected Z=%h Zero=%b Ov=%b Neg=%b",
                  nm, Z, Zero, Overflow, Negative, e.z, e.zero, e.ov, e.neg);
  endtask

  exp_t  mon_e;
  string mon_n;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check_now(mon_n, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [5:0]  rf;
    reset = 1'b0; A = '0; B = '0; Sign = 1'b0; ALUFun = '0;
    #12;
    check_now("reset_state", '0);
    @(negedge clk);
    reset = 1'b1;

    issue_exp(32'h80000001, 32'h80000001, 1'b1, 6'b000000, '{32'h2, 1'b0, 1'b1, 1'b1}, "add_signed_ovf");
    issue_exp(32'h80000001, 32'h80000001, 1'b0, 6'b000000, '{32'h2, 1'b0, 1'b1, 1'b0}, "add_unsigned_carry");
    issue_exp(32'h80000001, 32'h80000001, 1'b1, 6'b000001, '{32'h0, 1'b1, 1'b0, 1'b0}, "sub_equal");
    issue_exp(32'h00000001, 32'h00000002, 1'b0, 6'b000001, '{32'hFFFFFFFF, 1'b0, 1'b1, 1'b1}, "sub_borrow");
    issue_exp(32'h80000005, 32'h80000003, 1'b0, 6'b011000, '{32'h80000001, 1'b0, 1'b0, 1'b0}, "and");
    issue_exp(32'h80000005, 32'h80000003, 1'b0, 6'b011110, '{32'h80000007, 1'b0, 1'b0, 1'b0}, "or");
    issue_exp(32'h80000005, 32'h80000003, 1'b0, 6'b010110, '{32'h00000006, 1'b0, 1'b0, 1'b0}, "xor");
    issue_exp(32'h80000005, 32'h80000003, 1'b0, 6'b010001, '{32'h7FFFFFF8, 1'b0, 1'b0, 1'b0}, "nor");
    issue_exp(32'h80000005, 32'h80000003, 1'b0, 6'b011010, '{32'h80000005, 1'b0, 1'b0, 1'b0}, "pass_a");
    issue_exp(32'h00000004, 32'hFFFFFFFF, 1'b0, 6'b100000, '{32'hFFFFFFF0, 1'b0, 1'b0, 1'b0}, "sll4");
    issue_exp(32'h00000004, 32'h7FFFFFFF, 1'b0, 6'b100011, '{32'h07FFFFFF, 1'b0, 1'b0, 1'b0}, "sra4_pos");
    issue_exp(32'h00000004, 32'hFFFFFFFF, 1'b0, 6'b100011, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, "sra4_neg");
    issue_exp(32'h00000004, 32'hFFFFFFFF, 1'b0, 6'b100001, '{32'h0FFFFFFF, 1'b0, 1'b0, 1'b0}, "srl4");
    issue_exp(32'h00000020, 32'h12345678, 1'b0, 6'b100001, '{32'h12345678, 1'b0, 1'b0, 1'b0}, "srl_amount0");
    issue_exp(32'h80000001, 32'h80000001, 1'b1, 6'b110011, '{32'h1, 1'b0, 1'b0, 1'b0}, "eq");
    issue_exp(32'h80000001, 32'h00000002, 1'b1, 6'b111101, '{32'h1, 1'b0, 1'b1, 1'b1}, "lez");
    issue_exp(32'h00000000, 32'h00000000, 1'b1, 6'b111111, '{32'h0, 1'b1, 1'b0, 1'b0}, "gtz_zero");
    issue_exp(32'h80000001, 32'h00000002, 1'b1, 6'b110101, '{32'h1, 1'b0, 1'b1, 1'b1}, "lt_signed");
    issue_exp(32'h80000001, 32'h00000002, 1'b0, 6'b110101, '{32'h0, 1'b1, 1'b0, 1'b0}, "lt_unsigned");
    issue_exp(32'h00000005, 32'h00000003, 1'b1, 6'b101010, '{32'h0, 1'b1, 1'b0, 1'b0}, "unlisted");

    // Asynchronous reset mid-stream, then restart on the release edge.
    issue_exp(32'h80000001, 32'h80000001, 1'b1, 6'b000000, '{32'h2, 1'b0, 1'b1, 1'b1}, "pre_reset_add");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_now("async_reset", '0);
    @(posedge clk);
    #2;
    check_now("reset_held_over_edge", '0);
    @(negedge clk);
    reset = 1'b1;
    drive(32'h80000005, 32'h80000003, 1'b0, 6'b011110, '{32'h80000007, 1'b0, 1'b0, 1'b0}, "post_reset_or");

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
      if ($urandom_range(0, 1) == 0) rb = ra;
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : codes[$urandom_range(0, 15)];
      issue(ra, rb, 1'($urandom_range(0, 1)), rf, $sformatf("rand%0d_f%b", i, rf));
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
